// File: rtl/bcd_pkg.sv
// Shared BCD helpers: digit width, largest legal digit and the invalid-nibble test.
// Also used by the adder's +6 correction logic.
package bcd_pkg;

  localparam int          BCD_DIGIT_W = 4;
  localparam logic [3:0]  BCD_MAX     = 4'd9;

  // Nibbles 10..15 are not decimal digits.
  function automatic logic is_bad_bcd(input logic [BCD_DIGIT_W-1:0] nibble);
    return (nibble > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_check.sv
// Combinational per-digit validator: bit k of err_mask flags digit k of operand as > 9.
module bcd_digit_check
  import bcd_pkg::*;
#(
  parameter int DIGITS = 1
) (
  input  logic [BCD_DIGIT_W*DIGITS-1:0] operand,
  output logic [DIGITS-1:0]             err_mask
);

  always_comb begin
    err_mask = '0;
    for (int k = 0; k < DIGITS; k++) begin
      err_mask[k] = is_bad_bcd(operand[k*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end
  end

endmodule

// File: rtl/check_err.sv
// Registered packed-BCD operand checker: per-digit masks, per-operand flags,
// a sticky error flag and a saturating count of erroring valid cycles.
module check_err
  import bcd_pkg::*;
#(
  parameter int DIGITS = 1,
  parameter int CNT_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid_in,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] in1,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] in2,
  input  logic                          clr_sticky,
  output logic                          valid_out,
  output logic                          input_err1,
  output logic                          input_err2,
  output logic [DIGITS-1:0]             err_mask1,
  output logic [DIGITS-1:0]             err_mask2,
  output logic                          err_sticky,
  output logic [CNT_W-1:0]              err_count
);

  // Handshake: there is no ready. valid_in qualifies in1/in2 for exactly the
  // cycle it is high; valid_out is high for the one cycle its results appear.
  // With valid_in low, operands are ignored and result flags hold.

  logic [DIGITS-1:0] mask1_c, mask2_c;

  bcd_digit_check #(.DIGITS(DIGITS)) u_check1 (
    .operand  (in1),
    .err_mask (mask1_c)
  );

  bcd_digit_check #(.DIGITS(DIGITS)) u_check2 (
    .operand  (in2),
    .err_mask (mask2_c)
  );

  logic              valid_q,  valid_d;
  logic              err1_q,   err1_d;
  logic              err2_q,   err2_d;
  logic [DIGITS-1:0] mask1_q,  mask1_d;
  logic [DIGITS-1:0] mask2_q,  mask2_d;
  logic              sticky_q, sticky_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              any_err;

  always_comb begin
    valid_d  = valid_in;
    mask1_d  = mask1_q;
    mask2_d  = mask2_q;
    err1_d   = err1_q;
    err2_d   = err2_q;
    count_d  = count_q;
    // Gate with valid_in so unknown operands on idle cycles cannot leak in.
    any_err  = valid_in && ((|mask1_c) || (|mask2_c));

    if (valid_in) begin
      mask1_d = mask1_c;
      mask2_d = mask2_c;
      err1_d  = |mask1_c;
      err2_d  = |mask2_c;
    end

    sticky_d = (sticky_q || any_err) && !clr_sticky;

    if (clr_sticky) begin
      count_d = '0;
    end else if (any_err && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      err1_q   <= 1'b0;
      err2_q   <= 1'b0;
      mask1_q  <= '0;
      mask2_q  <= '0;
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      err1_q   <= err1_d;
      err2_q   <= err2_d;
      mask1_q  <= mask1_d;
      mask2_q  <= mask2_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign valid_out  = valid_q;
  assign input_err1 = err1_q;
  assign input_err2 = err2_q;
  assign err_mask1  = mask1_q;
  assign err_mask2  = mask2_q;
  assign err_sticky = sticky_q;
  assign err_count  = count_q;

endmodule

// File: tb/tb_check_err.sv
// Directed bench for check_err: a 1-digit/8-bit-count instance and a
// 2-digit/2-bit-count instance sharing clock and reset.
module tb_check_err;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: DIGITS=1, CNT_W=8
  logic       v_a, clr_a;
  logic [3:0] in1_a, in2_a;
  logic       vo_a, e1_a, e2_a, st_a;
  logic [0:0] m1_a, m2_a;
  logic [7:0] cnt_a;

  check_err #(.DIGITS(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .valid_in(v_a), .in1(in1_a), .in2(in2_a),
    .clr_sticky(clr_a), .valid_out(vo_a), .input_err1(e1_a), .input_err2(e2_a),
    .err_mask1(m1_a), .err_mask2(m2_a), .err_sticky(st_a), .err_count(cnt_a)
  );

  // Instance B: DIGITS=2, CNT_W=2
  logic       v_b, clr_b;
  logic [7:0] in1_b, in2_b;
  logic       vo_b, e1_b, e2_b, st_b;
  logic [1:0] m1_b, m2_b;
  logic [1:0] cnt_b;

  check_err #(.DIGITS(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .valid_in(v_b), .in1(in1_b), .in2(in2_b),
    .clr_sticky(clr_b), .valid_out(vo_b), .input_err1(e1_b), .input_err2(e2_b),
    .err_mask1(m1_b), .err_mask2(m2_b), .err_sticky(st_b), .err_count(cnt_b)
  );

  // Observed fields: {valid_out, err1, err2, mask1, mask2, sticky, count}
  logic [13:0] obs_a;
  logic [9:0]  obs_b;
  assign obs_a = {vo_a, e1_a, e2_a, m1_a, m2_a, st_a, cnt_a};
  assign obs_b = {vo_b, e1_b, e2_b, m1_b, m2_b, st_b, cnt_b};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    v_a = 1'b1; in1_a = 4'hF; in2_a = 4'hF; clr_a = 1'b0;
    v_b = 1'b1; in1_b = 8'hFF; in2_b = 8'hFF; clr_b = 1'b0;
    cycle();
    cycle();
    n_checks++;
    if (obs_a !== 14'd0) $display("FAIL reset_a: got %b want %b", obs_a, 14'd0);
    else n_pass++;
    n_checks++;
    if (obs_b !== 10'd0) $display("FAIL reset_b: got %b want %b", obs_b, 10'd0);
    else n_pass++;
    rst_n = 1'b1;
    v_b = 1'b0;
  endtask

  task automatic test_valid();
    v_a = 1'b1; in1_a = 4'b0011; in2_a = 4'b1001;
    cycle();
    n_checks++;
    if (obs_a !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0})
      $display("FAIL valid_ops: got %b want %b", obs_a, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    else n_pass++;
  endtask

  task automatic test_boundary();
    in1_a = 4'b1010; in2_a = 4'b1001;
    cycle();
    n_checks++;
    if (obs_a !== {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1})
      $display("FAIL boundary_10: got %b want %b", obs_a, {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1});
    else n_pass++;
    in1_a = 4'b1001;
    cycle();
    n_checks++;
    if (obs_a !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1})
      $display("FAIL boundary_9: got %b want %b", obs_a, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1});
    else n_pass++;
  endtask

  task automatic test_both_invalid();
    in1_a = 4'b1111; in2_a = 4'b1100;
    cycle();
    n_checks++;
    if (obs_a !== {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd2})
      $display("FAIL both_invalid: got %b want %b", obs_a, {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd2});
    else n_pass++;
  endtask

  task automatic test_idle_hold();
    v_a = 1'b0; in1_a = 4'bxxxx; in2_a = 4'bxxxx;
    cycle();
    n_checks++;
    if (obs_a !== {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd2})
      $display("FAIL idle_hold: got %b want %b", obs_a, {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd2});
    else n_pass++;
  endtask

  task automatic test_clear_priority();
    v_a = 1'b1; clr_a = 1'b1; in1_a = 4'b1101; in2_a = 4'b0000;
    cycle();
    n_checks++;
    if (obs_a !== {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0})
      $display("FAIL clear_priority: got %b want %b", obs_a, {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
    else n_pass++;
    v_a = 1'b0; clr_a = 1'b0; in1_a = 4'b1111; in2_a = 4'b1111;
    cycle();
    n_checks++;
    if (obs_a !== {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0})
      $display("FAIL clear_then_idle: got %b want %b", obs_a, {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
    else n_pass++;
  endtask

  task automatic test_multi_digit();
    v_b = 1'b1; in1_b = 8'b1011_0101; in2_b = 8'b0100_1110;
    cycle();
    n_checks++;
    if (obs_b !== {1'b1, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1, 2'd1})
      $display("FAIL multi_b5_4e: got %b want %b", obs_b, {1'b1, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1, 2'd1});
    else n_pass++;
    in1_b = 8'h99; in2_b = 8'h00;
    cycle();
    n_checks++;
    if (obs_b !== {1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'd1})
      $display("FAIL multi_99_00: got %b want %b", obs_b, {1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'd1});
    else n_pass++;
    in1_b = 8'hA0; in2_b = 8'h09;
    cycle();
    n_checks++;
    if (obs_b !== {1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 2'd2})
      $display("FAIL multi_a0_09: got %b want %b", obs_b, {1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 2'd2});
    else n_pass++;
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    exp_cnt = 2'd2;
    in1_b = 8'hFF; in2_b = 8'hCC;
    for (int i = 0; i < 3; i++) begin
      if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
      cycle();
      n_checks++;
      if (obs_b !== {1'b1, 1'b1, 1'b1, 2'b11, 2'b11, 1'b1, exp_cnt})
        $display("FAIL saturate_%0d: got %b want %b", i, obs_b, {1'b1, 1'b1, 1'b1, 2'b11, 2'b11, 1'b1, exp_cnt});
      else n_pass++;
    end
    v_b = 1'b0; clr_b = 1'b1;
    cycle();
    n_checks++;
    if (obs_b !== {1'b0, 1'b1, 1'b1, 2'b11, 2'b11, 1'b0, 2'd0})
      $display("FAIL clear_idle_b: got %b want %b", obs_b, {1'b0, 1'b1, 1'b1, 2'b11, 2'b11, 1'b0, 2'd0});
    else n_pass++;
    clr_b = 1'b0;
  endtask

  task automatic test_reset_mid_stream();
    v_a = 1'b1; in1_a = 4'hF; in2_a = 4'hE;
    v_b = 1'b1; in1_b = 8'hFF; in2_b = 8'hFF;
    rst_n = 1'b0;
    cycle();
    n_checks++;
    if (obs_a !== 14'd0) $display("FAIL reset_mid_a: got %b want %b", obs_a, 14'd0);
    else n_pass++;
    n_checks++;
    if (obs_b !== 10'd0) $display("FAIL reset_mid_b: got %b want %b", obs_b, 10'd0);
    else n_pass++;
    rst_n = 1'b1;
    v_a = 1'b0; v_b = 1'b0;
    cycle();
  endtask

  initial begin
    test_reset();
    test_valid();
    test_boundary();
    test_both_invalid();
    test_idle_hold();
    test_clear_priority();
    test_multi_digit();
    test_saturation();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
